// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: walks two operand memories for len element pairs, drives an
// external MAC through clear/accumulate strobes, and registers the final accumulator value.
module mac_dot_sequencer #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] len,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  input  logic [DW-1:0] a_rdata,
  input  logic [DW-1:0] b_rdata,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_mode,
  input  logic [DW-1:0] mac_o,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_CAPT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] base_a_q, base_a_d;
  logic [AW-1:0] base_b_q, base_b_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b_addr_q, b_addr_d;
  logic [DW-1:0] result_q, result_d;
  logic          mac_en_q, mac_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      idx_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      result_q <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      idx_q    <= idx_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      result_q <= result_d;
      mac_en_q <= mac_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    idx_d    = idx_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    result_d = result_q;
    mac_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d    = len;
          base_a_d = base_a;
          base_b_d = base_b;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        idx_d = '0;
        if (len_q == '0) begin
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Address wraps mod 2^AW; mac_en lags one cycle to line up with read data.
        a_addr_d = base_a_q + idx_q;
        b_addr_d = base_b_q + idx_q;
        idx_d    = idx_q + AW'(1);
        mac_en_d = 1'b1;
        if (idx_q == len_q - AW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_CAPT;
      S_CAPT: begin
        result_d = mac_o;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every transition and suppresses any further accumulate.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      mac_en_d = 1'b0;
      result_d = result_q;
    end
  end

  assign a_addr   = a_addr_d;
  assign b_addr   = b_addr_d;
  assign mac_a    = a_rdata;
  assign mac_b    = b_rdata;
  assign mac_clr  = (state_q == S_CLR);
  assign mac_en   = mac_en_q;
  assign mac_mode = 1'b1;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a behavioural operand memory and MAC.
module tb_mac_dot_sequencer;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] len = '0;
  logic [AW-1:0] base_a = '0;
  logic [AW-1:0] base_b = '0;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_rdata = '0;
  logic [DW-1:0] b_rdata = '0;
  logic [DW-1:0] mac_a, mac_b;
  logic          mac_clr, mac_en, mac_mode;
  logic [DW-1:0] mac_o;
  logic          busy, done;
  logic [DW-1:0] result;
  logic [2:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] acc;
  logic [AW-1:0] a_log [16];
  logic [AW-1:0] b_log [16];

  mac_dot_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .base_a(base_a), .base_b(base_b), .a_addr(a_addr), .b_addr(b_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .mac_a(mac_a), .mac_b(mac_b),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_mode(mac_mode), .mac_o(mac_o),
    .busy(busy), .done(done), .result(result), .state_o(state_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // operand memories: one-cycle read latency
  always @(posedge clk) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
  end

  // external MAC
  always @(posedge clk or posedge rst) begin
    if (rst)          acc <= '0;
    else if (mac_clr) acc <= '0;
    else if (mac_en)  acc <= acc + mac_a * mac_b;
  end
  assign mac_o = acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
  endtask

  // Runs one operation from IDLE and checks timing, strobes and result.
  task automatic run_op(input string tag, input logic [AW-1:0] n, input logic [AW-1:0] ba,
                        input logic [AW-1:0] bb, input logic [DW-1:0] exp_res,
                        input bit pulse_again);
    int clr_cnt, clr_cyc, en_cnt, en_first, done_cnt, done_cyc, overlap, exp_done;
    clr_cnt = 0; clr_cyc = -1; en_cnt = 0; en_first = -1;
    done_cnt = 0; done_cyc = -1; overlap = 0;
    exp_done = (n == 0) ? 2 : int'(n) + 4;
    @(negedge clk);
    start = 1'b1; len = n; base_a = ba; base_b = bb;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= int'(n) + 8; cyc++) begin
      @(negedge clk);
      if (mac_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (mac_en) begin en_cnt++; if (en_first < 0) en_first = cyc; end
      if (mac_en && mac_clr) overlap++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc >= 2 && cyc < 2 + int'(n) && cyc - 2 < 16) begin
        a_log[cyc-2] = a_addr;
        b_log[cyc-2] = b_addr;
      end
      if (pulse_again && cyc == 2) begin
        start = 1'b1; len = 8'd7; base_a = 8'h00; base_b = 8'h00;
      end
      if (pulse_again && cyc == 3) start = 1'b0;
    end
    chk({tag, "_clr_cnt"}, clr_cnt, 1);
    chk({tag, "_clr_cyc"}, clr_cyc, 1);
    chk({tag, "_en_cnt"}, en_cnt, int'(n));
    if (n != 0) chk({tag, "_en_first"}, en_first, 3);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int dcnt;
    clear_mem();
    // reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clr", mac_clr, 0);
    chk("rst_en", mac_en, 0);
    chk("rst_result", result, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_state", state_o, 0);
    chk("mac_mode", mac_mode, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // small signed dot product: -10*1 + 3*4 = 2
    mem_a[0] = 32'hFFFF_FFF6; mem_a[1] = 32'd3;
    mem_b[0] = 32'd1;         mem_b[1] = 32'd4;
    run_op("basic", 8'd2, 8'h00, 8'h00, 32'h0000_0002, 1'b0);

    // zero length
    run_op("len0", 8'd0, 8'h00, 8'h00, 32'h0, 1'b0);

    // address wrap: 1*5 + 2*6 + 3*7 + 4*8 = 70
    clear_mem();
    mem_a[8'hFE] = 1; mem_a[8'hFF] = 2; mem_a[8'h00] = 3; mem_a[8'h01] = 4;
    mem_b[8'h10] = 5; mem_b[8'h11] = 6; mem_b[8'h12] = 7; mem_b[8'h13] = 8;
    run_op("wrap", 8'd4, 8'hFE, 8'h10, 32'd70, 1'b0);
    chk("wrap_a0", a_log[0], 8'hFE);
    chk("wrap_a1", a_log[1], 8'hFF);
    chk("wrap_a2", a_log[2], 8'h00);
    chk("wrap_a3", a_log[3], 8'h01);
    chk("wrap_b3", b_log[3], 8'h13);
    chk("hold_a_addr", a_addr, 8'h01);
    chk("mac_a_pass", mac_a, a_rdata);

    // start with abort in IDLE is ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; len = 8'd3;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);

    // abort in the second RUN cycle of a len=5 run
    for (int k = 0; k < 5; k++) begin
      mem_a[8'h20 + k] = k + 1;
      mem_b[8'h40 + k] = 2;
    end
    @(negedge clk);
    start = 1'b1; len = 8'd5; base_a = 8'h20; base_b = 8'h40;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);                       // cycle 1: CLR
    @(negedge clk);                       // cycle 2: first RUN
    @(negedge clk);                       // cycle 3: second RUN
    chk("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_en_low", mac_en, 0);
    chk("abort_result_held", result, 32'd70);
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || mac_en) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op("after_abort", 8'd5, 8'h20, 8'h40, 32'd30, 1'b0);

    // second start while busy is ignored: 1*2 + 2*2 + 3*2 = 12
    mem_a[0] = 32'd100; mem_b[0] = 32'd100;
    run_op("restart", 8'd3, 8'h20, 8'h40, 32'd12, 1'b1);

    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; len = 8'd4; base_a = 8'h20; base_b = 8'h40;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_rst_en", mac_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_en", mac_en, 0);
    chk("arst_clr", mac_clr, 0);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_a_addr", a_addr, 0);
    chk("arst_b_addr", b_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_a[8'h80] = 32'd3; mem_b[8'h90] = 32'd7;
    run_op("post_rst", 8'd1, 8'h80, 8'h90, 32'd21, 1'b0);

    // maximum length: sum of 0..254 = 32385
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 32'd1;
      mem_b[k] = k;
    end
    run_op("maxlen", 8'd255, 8'h37, 8'h00, 32'd32385, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

Interface
REQ-001: Parameter AW, default 8, operand-memory address width.
REQ-002: Parameter DW, default 32, operand/result data width.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: start  input  1  one-cycle request to run a dot product; sampled only in IDLE.
REQ-006: abort  input  1  synchronous cancel of the active run.
REQ-007: len  input  AW  element-pair count, captured at start.
REQ-008: base_a / base_b  input  AW each  first operand addresses, captured at start.
REQ-009: a_addr / b_addr  output  AW each  operand memory read addresses; read data is valid one cycle later.
REQ-010: a_rdata / b_rdata  input  DW each  operand memory read data.
REQ-011: mac_a / mac_b  output  DW each  MAC operands, driven combinationally from a_rdata / b_rdata.
REQ-012: mac_clr  output  1  MAC accumulator synchronous clear to 0.
REQ-013: mac_en  output  1  MAC accumulate strobe (acc <= acc + mac_a*mac_b).
REQ-014: mac_mode  output  1  MAC mode select; tied to 1 (MAC mode).
REQ-015: mac_o  input  DW  MAC accumulator output.
REQ-016: busy  output  1  high in every state except IDLE.
REQ-017: done  output  1  one-cycle completion pulse.
REQ-018: result  output  DW  registered final accumulator value; held until the next completion.

Function
REQ-019: The FSM SHALL have the states IDLE, CLR, RUN, DRAIN, CAPT and DONE.
REQ-020: start in IDLE SHALL capture len, base_a and base_b and go to CLR. start outside IDLE SHALL be ignored.
REQ-021: In CLR the block SHALL assert mac_clr for exactly one cycle and clear the element index i to 0.
- Next state is RUN if len != 0.
- Next state is DONE if len == 0, with result <= 0 and no mac_en issued.
REQ-022: In RUN the block SHALL drive a_addr = base_a + i and b_addr = base_b + i, both mod 2^AW (wrap-around permitted), and increment i each cycle.
- RUN lasts exactly len cycles, then the FSM goes to DRAIN.
REQ-023: mac_en SHALL be a one-cycle-delayed copy of the "RUN issuing" condition, so mac_en is high exactly len cycles, aligned with valid read data.
REQ-024: DRAIN SHALL last one cycle and go to CAPT. CAPT SHALL register result <= mac_o and go to DONE.
REQ-025: DONE SHALL assert done for one cycle and go to IDLE.
REQ-026: For len = N > 0, done SHALL be high in cycle N+4, counting the start-sampling cycle as cycle 0.
REQ-027: mac_clr and mac_en SHALL never be asserted in the same cycle.
REQ-028: Outside RUN, a_addr and b_addr SHALL hold their last value.
REQ-029: abort in any non-IDLE state SHALL force IDLE on the next edge.
- mac_en is low from the next cycle onward.
- No done pulse is issued and result is unchanged.
- abort takes priority over all other transitions.
REQ-030: start and abort asserted together in IDLE SHALL be ignored (remain IDLE).
REQ-031: len = 2^AW - 1 SHALL be supported. The index counter SHALL be AW bits wide with no overflow into addresses beyond wrap.

Reset
REQ-032: rst high SHALL immediately force the following, regardless of clock:
- state IDLE;
- busy, done, mac_clr and mac_en = 0;
- result = 0 and a_addr = b_addr = 0;
- captured len and bases = 0.
REQ-033: rst asserted mid-run SHALL abandon the run with no done pulse. The first start after rst deasserts SHALL behave as from power-up.

Verification
REQ-034: Memory A = {-10, 3}, memory B = {1, 4}, base 0, len = 2 -> mac_clr in cycle 1, mac_en in cycles 3-4, done in cycle 6, result = 32'h00000002.
REQ-035: len = 0 -> mac_clr one cycle, done in cycle 2, result = 0, mac_en never high.
REQ-036: base_a = 8'hFE, len = 4 -> a_addr sequence FE, FF, 00, 01, with the correct accumulated sum.
REQ-037: Abort in the second RUN cycle of a len = 5 run -> IDLE next cycle, no done, result holds its prior value. A start two cycles later completes normally.
REQ-038: Start pulsed again while busy -> ignored: a single done pulse, with the result of the first operands.
REQ-039: rst asserted asynchronously mid-RUN -> all outputs 0 within the same cycle. A following len = 1 run (3 x 7) -> result = 21 in cycle 5.
